// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, default baud/stop constants
// used by both the transmitter and the receiver, and counter-width helpers.
package fifo_uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } state_t;

   localparam int DEFAULT_DBIT     = 8;
   localparam int DEFAULT_SB_TICK  = 16;
   localparam int DEFAULT_DVSR     = 163;
   localparam int DEFAULT_DVSR_BIT = 8;

   // Oversample tick counter width: 4 bits covers a 16-tick bit, longer
   // stop bits (more than 16 ticks) need log2 of the stop length.
   function automatic int s_width(input int sb_tick);
      return (sb_tick > 16) ? $clog2(sb_tick) : 4;
   endfunction

   // Data bit index width; never narrower than one bit.
   function automatic int n_width(input int dbit);
      return (dbit > 1) ? $clog2(dbit) : 1;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_mod_m_counter.sv
// Free-running modulo-M counter used as the 16x baud tick generator.
// max_tick is registered and is high exactly while q == M-1.
module mod_m_counter
   import fifo_uart_tx_pkg::*;
#(
   parameter int M = DEFAULT_DVSR,
   parameter int N = DEFAULT_DVSR_BIT
) (
   input  logic         clk,
   input  logic         reset,
   output logic         max_tick,
   output logic [N-1:0] q
);

   logic [N-1:0] q_r;
   logic [N-1:0] q_next_s;
   logic         tick_r;

   // Next count: wrap to zero after M-1.
   always_comb begin
      q_next_s = q_r + N'(1);
      if (q_r == N'(M - 1)) begin
         q_next_s = '0;
      end else begin
         q_next_s = q_r + N'(1);
      end
   end

   // Count register plus a registered tick flag aligned with q == M-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r    <= '0;
         tick_r <= (M == 1) ? 1'b1 : 1'b0;
      end else begin
         q_r    <= q_next_s;
         tick_r <= (q_next_s == N'(M - 1));
      end
   end

   assign q        = q_r;
   assign max_tick = tick_r;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO: pops one word whenever the FIFO is
// non-empty while idle, then sends it as start / DBIT data (LSB first) / stop.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int DBIT     = DEFAULT_DBIT,
   parameter int SB_TICK  = DEFAULT_SB_TICK,
   parameter int DVSR     = DEFAULT_DVSR,
   parameter int DVSR_BIT = DEFAULT_DVSR_BIT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fifo_empty,
   input  logic [DBIT-1:0] fifo_data,
   output logic            fifo_rd,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int S_W = s_width(SB_TICK);
   localparam int N_W = n_width(DBIT);

   state_t                state_r;
   logic [S_W-1:0]        s_r;
   logic [N_W-1:0]        n_r;
   logic [DBIT-1:0]       b_r;
   logic                  tx_r;
   logic                  done_r;
   logic                  max_tick_s;
   logic [DVSR_BIT-1:0]   baud_q_s;
   logic                  tick_s;

   mod_m_counter #(
      .M (DVSR),
      .N (DVSR_BIT)
   ) u_baud (
      .clk      (clk),
      .reset    (reset),
      .max_tick (max_tick_s),
      .q        (baud_q_s)
   );

   // The registered tick is qualified with the count value, so a single
   // upset in the tick flop cannot advance the frame on its own.
   assign tick_s = max_tick_s & (baud_q_s == DVSR_BIT'(DVSR - 1));

   // Frame FSM: state, oversample/bit counters, shift register and the
   // registered line/done outputs (tx reflects the state one clk later).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         s_r     <= '0;
         n_r     <= '0;
         b_r     <= '0;
         tx_r    <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               tx_r <= 1'b1;
               if (!fifo_empty) begin
                  b_r     <= fifo_data;
                  s_r     <= '0;
                  state_r <= START;
               end
            end
            START: begin
               tx_r <= 1'b0;
               if (tick_s) begin
                  if (s_r == S_W'(15)) begin
                     s_r     <= '0;
                     n_r     <= '0;
                     state_r <= DATA;
                  end else begin
                     s_r <= s_r + S_W'(1);
                  end
               end
            end
            DATA: begin
               tx_r <= b_r[0];
               if (tick_s) begin
                  if (s_r == S_W'(15)) begin
                     s_r <= '0;
                     b_r <= {1'b0, b_r[DBIT-1:1]};
                     if (n_r == N_W'(DBIT - 1)) begin
                        state_r <= STOP;
                     end else begin
                        n_r <= n_r + N_W'(1);
                     end
                  end else begin
                     s_r <= s_r + S_W'(1);
                  end
               end
            end
            STOP: begin
               tx_r <= 1'b1;
               if (tick_s) begin
                  if (s_r == S_W'(SB_TICK - 1)) begin
                     done_r  <= 1'b1;
                     state_r <= IDLE;
                  end else begin
                     s_r <= s_r + S_W'(1);
                  end
               end
            end
            default: begin
               tx_r    <= 1'b1;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Pop strobe must coincide with the capture cycle, so it is decoded from
   // the state register; it is forced low while reset is held.
   always_comb begin
      fifo_rd = 1'b0;
      if (!reset && (state_r == IDLE) && !fifo_empty) begin
         fifo_rd = 1'b1;
      end else begin
         fifo_rd = 1'b0;
      end
   end

   assign tx_busy      = (state_r != IDLE) | fifo_rd;
   assign tx           = tx_r;
   assign tx_done_tick = done_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a queue models the FIFO, every cycle
// of the line is logged, and frames are decoded from the log with fixed
// 64-clk bit windows counted back from tx_done_tick.
module tb_fifo_uart_tx;

   localparam int BIT_CLKS = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       fifo_empty_m = 1'b1;
   logic [7:0] fifo_data_m = 8'h00;
   bit         sel = 1'b0;

   logic empty_a, empty_b, rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

   assign empty_a = sel ? 1'b1 : fifo_empty_m;
   assign empty_b = sel ? fifo_empty_m : 1'b1;

   fifo_uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_BIT(3)) dut_a (
      .clk(clk), .reset(reset), .fifo_empty(empty_a), .fifo_data(fifo_data_m),
      .fifo_rd(rd_a), .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a));

   fifo_uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(4), .DVSR_BIT(3)) dut_b (
      .clk(clk), .reset(reset), .fifo_empty(empty_b), .fifo_data(fifo_data_m),
      .fifo_rd(rd_b), .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   byte unsigned fifo_q[$];
   bit   rand_mode = 1'b0;
   logic tx_h[$];
   bit   done_h[$];
   bit   busy_h[$];
   bit   rd_h[$];
   int   pops = 0;
   int   bad_pops = 0;
   logic s_tx, s_rd, s_busy, s_done;

   typedef struct packed {
      bit       found;
      int       fall;
      int       start_len;
      bit       start_ok;
      bit [7:0] data;
      bit       data_ok;
      bit       stop_ok;
      int       done_idx;
   } frame_t;

   task automatic refresh();
      fifo_empty_m = (fifo_q.size() == 0);
      fifo_data_m  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic clear_logs();
      tx_h.delete(); done_h.delete(); busy_h.delete(); rd_h.delete();
      pops = 0; bad_pops = 0;
   endtask

   // One clock: sample at negedge, apply the pop and new inputs after posedge.
   task automatic cycle();
      @(negedge clk);
      s_tx   = sel ? tx_b   : tx_a;
      s_rd   = sel ? rd_b   : rd_a;
      s_busy = sel ? busy_b : busy_a;
      s_done = sel ? done_b : done_a;
      tx_h.push_back(s_tx); done_h.push_back(s_done);
      busy_h.push_back(s_busy); rd_h.push_back(s_rd);
      if (s_rd === 1'b1) begin
         pops++;
         if (fifo_q.size() == 0) bad_pops++;
      end
      @(posedge clk);
      #1;
      if (s_rd === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (rand_mode) begin
         fifo_empty_m = 1'($urandom);
         fifo_data_m  = 8'($urandom);
      end else begin
         refresh();
      end
   endtask

   // Reference frame decoder: locate the start edge and the done pulse, then
   // carve stop (stop_clks, ending at the done cycle), 8 data bits of 64 clks
   // before it, and whatever remains back to the falling edge is the start bit.
   function automatic frame_t decode(input int from, input int stop_clks);
      frame_t r;
      int stop_begin, data_begin, base;
      r = '0;
      r.fall = -1;
      r.done_idx = -1;
      for (int i = (from < 1) ? 1 : from; i < tx_h.size(); i++) begin
         if (tx_h[i-1] === 1'b1 && tx_h[i] === 1'b0) begin
            r.fall = i;
            break;
         end
      end
      if (r.fall < 0) return r;
      for (int i = r.fall + 1; i < done_h.size(); i++) begin
         if (done_h[i]) begin
            r.done_idx = i;
            break;
         end
      end
      if (r.done_idx < 0) return r;
      r.found = 1'b1;
      stop_begin = r.done_idx - stop_clks + 1;
      data_begin = stop_begin - 8 * BIT_CLKS;
      r.start_len = data_begin - r.fall;
      if (r.start_len < 1) return r;
      r.start_ok = 1'b1;
      for (int i = r.fall; i < data_begin; i++)
         if (tx_h[i] !== 1'b0) r.start_ok = 1'b0;
      r.data_ok = 1'b1;
      for (int b = 0; b < 8; b++) begin
         base = data_begin + b * BIT_CLKS;
         r.data[b] = (tx_h[base] === 1'b1);
         for (int k = 0; k < BIT_CLKS; k++)
            if (tx_h[base + k] !== tx_h[base]) r.data_ok = 1'b0;
      end
      r.stop_ok = 1'b1;
      for (int i = stop_begin; i <= r.done_idx; i++)
         if (tx_h[i] !== 1'b1) r.stop_ok = 1'b0;
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         n_checks++;
         if ({s_tx, s_rd, s_busy, s_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_hold: {tx,rd,busy,done} got %b expected 1000", {s_tx, s_rd, s_busy, s_done});
         end
      end
      rand_mode = 1'b0;
      refresh();
      reset = 1'b0;
      clear_logs();
      for (int i = 0; i < 1000; i++) begin
         cycle();
         n_checks++;
         if ({s_tx, s_rd} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_empty: {tx,rd} got %b expected 10 at cycle %0d", {s_tx, s_rd}, i);
         end
      end
   endtask

   task automatic test_single_byte();
      frame_t fr;
      int ndone, pop_idx;
      bit got;
      clear_logs();
      fifo_q.push_back(8'hA5);
      refresh();
      got = 1'b0;
      for (int g = 0; g < 2000 && !got; g++) begin
         cycle();
         if (s_done === 1'b1) got = 1'b1;
      end
      for (int i = 0; i < 8; i++) cycle();
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL single_timeout: done seen %0d expected 1", got);
      end
      fr = decode(0, BIT_CLKS);
      ndone = 0; pop_idx = -1;
      foreach (done_h[i]) if (done_h[i]) ndone++;
      foreach (rd_h[i]) if (rd_h[i] && pop_idx < 0) pop_idx = i;
      n_checks++;
      if (pops != 1) begin n_fail++; $display("FAIL single_pops: got %0d expected 1", pops); end
      n_checks++;
      if (fr.data !== 8'hA5 || !fr.data_ok) begin
         n_fail++; $display("FAIL single_data: got %h (stable=%0d) expected a5", fr.data, fr.data_ok);
      end
      n_checks++;
      if (fr.start_len < 61 || fr.start_len > 64 || !fr.start_ok) begin
         n_fail++; $display("FAIL single_start: length %0d (low=%0d) expected 61..64", fr.start_len, fr.start_ok);
      end
      n_checks++;
      if (!fr.stop_ok) begin n_fail++; $display("FAIL single_stop: got %0d expected 1", fr.stop_ok); end
      n_checks++;
      if (ndone != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", ndone); end
      n_checks++;
      if (pop_idx < 0 || busy_h[pop_idx] !== 1'b1 || fr.fall != pop_idx + 2) begin
         n_fail++; $display("FAIL single_pop_to_start: pop %0d fall %0d expected fall = pop+2 with busy", pop_idx, fr.fall);
      end
      n_checks++;
      if (fifo_q.size() != 0 || s_busy !== 1'b0 || s_tx !== 1'b1) begin
         n_fail++; $display("FAIL single_end: fifo %0d busy %b tx %b expected 0 0 1", fifo_q.size(), s_busy, s_tx);
      end
   endtask

   task automatic test_back_to_back();
      frame_t fr;
      byte unsigned exp[3];
      int from, prev_done, ndone, run, max_run, first_pop, last_done;
      exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
      clear_logs();
      for (int k = 0; k < 3; k++) fifo_q.push_back(exp[k]);
      refresh();
      ndone = 0;
      for (int g = 0; g < 4000 && ndone < 3; g++) begin
         cycle();
         if (s_done === 1'b1) ndone++;
      end
      for (int i = 0; i < 8; i++) cycle();
      n_checks++;
      if (ndone != 3 || pops != 3 || bad_pops != 0) begin
         n_fail++; $display("FAIL b2b_counts: done %0d pops %0d bad %0d expected 3 3 0", ndone, pops, bad_pops);
      end
      from = 0; prev_done = -1; first_pop = -1; last_done = -1;
      for (int k = 0; k < 3; k++) begin
         fr = decode(from, BIT_CLKS);
         n_checks++;
         if (!fr.found || fr.data !== exp[k] || !fr.data_ok || !fr.stop_ok) begin
            n_fail++; $display("FAIL b2b_frame%0d: got %h (found %0d stable %0d stop %0d) expected %h",
                               k, fr.data, fr.found, fr.data_ok, fr.stop_ok, exp[k]);
         end
         n_checks++;
         if (fr.start_len < 61 || fr.start_len > 64 || !fr.start_ok) begin
            n_fail++; $display("FAIL b2b_start%0d: length %0d expected 61..64", k, fr.start_len);
         end
         if (k > 0) begin
            n_checks++;
            if (fr.fall - prev_done < 1 || fr.fall - prev_done > 2) begin
               n_fail++; $display("FAIL b2b_gap%0d: got %0d clks expected 1..2", k, fr.fall - prev_done);
            end
         end
         prev_done = fr.done_idx;
         from = fr.done_idx + 1;
         last_done = fr.done_idx;
      end
      foreach (rd_h[i]) if (rd_h[i] && first_pop < 0) first_pop = i;
      run = 0; max_run = 0;
      for (int i = (first_pop < 0) ? 0 : first_pop; i < last_done; i++) begin
         run = busy_h[i] ? 0 : run + 1;
         if (run > max_run) max_run = run;
      end
      n_checks++;
      if (max_run > 1) begin n_fail++; $display("FAIL b2b_busy_gap: got %0d clks expected <= 1", max_run); end
   endtask

   task automatic test_random_bytes();
      frame_t fr;
      byte unsigned exp_q[$];
      byte unsigned b;
      int from;
      bit got;
      clear_logs();
      for (int k = 0; k < 4; k++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         fifo_q.push_back(b);
         refresh();
         got = 1'b0;
         for (int g = 0; g < 1500 && !got; g++) begin
            cycle();
            if (s_done === 1'b1) got = 1'b1;
         end
         n_checks++;
         if (!got) begin n_fail++; $display("FAIL rand_timeout%0d: done %0d expected 1", k, got); end
         for (int i = 0; i < $urandom_range(2, 100); i++) cycle();
      end
      n_checks++;
      if (pops != 4) begin n_fail++; $display("FAIL rand_pops: got %0d expected 4", pops); end
      from = 0;
      for (int k = 0; k < 4; k++) begin
         fr = decode(from, BIT_CLKS);
         n_checks++;
         if (fr.data !== exp_q[k] || !fr.data_ok || !fr.stop_ok || !fr.start_ok ||
             fr.start_len < 61 || fr.start_len > 64) begin
            n_fail++; $display("FAIL rand_frame%0d: got %h start %0d expected %h start 61..64",
                               k, fr.data, fr.start_len, exp_q[k]);
         end
         from = fr.done_idx + 1;
      end
   endtask

   task automatic test_reset_mid_frame();
      bit fell;
      clear_logs();
      fifo_q.push_back(8'h3C);
      refresh();
      fell = 1'b0;
      for (int g = 0; g < 200 && !fell; g++) begin
         cycle();
         if (tx_h.size() > 1 && tx_h[tx_h.size()-2] === 1'b1 && s_tx === 1'b0) fell = 1'b1;
      end
      for (int i = 0; i < 60 + 3 * BIT_CLKS + 32; i++) cycle();
      n_checks++;
      if (!fell || s_busy !== 1'b1 || s_tx !== 1'b1) begin
         n_fail++; $display("FAIL midreset_pre: started %0d busy %b tx %b expected 1 1 1", fell, s_busy, s_tx);
      end
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 1'b0 || done_a !== 1'b0) begin
         n_fail++; $display("FAIL midreset_async: {tx,busy,rd,done} got %b expected 1000", {tx_a, busy_a, rd_a, done_a});
      end
      for (int i = 0; i < 3; i++) cycle();
      reset = 1'b0;
      clear_logs();
      for (int i = 0; i < 300; i++) begin
         cycle();
         n_checks++;
         if ({s_tx, s_rd, s_busy} !== 3'b100) begin
            n_fail++; $display("FAIL midreset_after: {tx,rd,busy} got %b expected 100 at cycle %0d", {s_tx, s_rd, s_busy}, i);
         end
      end
   endtask

   task automatic test_long_stop();
      frame_t fr;
      bit got;
      sel = 1'b1;
      refresh();
      clear_logs();
      fifo_q.push_back(8'h81);
      refresh();
      got = 1'b0;
      for (int g = 0; g < 2000 && !got; g++) begin
         cycle();
         if (s_done === 1'b1) got = 1'b1;
      end
      for (int i = 0; i < 8; i++) cycle();
      fr = decode(0, 2 * BIT_CLKS);
      n_checks++;
      if (!got || pops != 1) begin n_fail++; $display("FAIL long_counts: done %0d pops %0d expected 1 1", got, pops); end
      n_checks++;
      if (fr.data !== 8'h81 || !fr.data_ok) begin
         n_fail++; $display("FAIL long_data: got %h (stable %0d) expected 81", fr.data, fr.data_ok);
      end
      n_checks++;
      if (!fr.stop_ok || tx_h[fr.done_idx - 2 * BIT_CLKS] !== 1'b1) begin
         n_fail++; $display("FAIL long_stop: stop high %0d expected 128 clks high", fr.stop_ok);
      end
      n_checks++;
      if (fr.start_len < 61 || fr.start_len > 64 || !fr.start_ok) begin
         n_fail++; $display("FAIL long_start: length %0d expected 61..64", fr.start_len);
      end
      sel = 1'b0;
      refresh();
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_random_bytes();
      test_reset_mid_frame();
      test_long_stop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
